// File: rtl/zynet_argmax_classifier.sv
// Sequential argmax over one registered score vector per inference; result on ready/valid.
// Optional threshold reject flag (thresh_i / reject_o) enabled by defining ZYNET_ARGMAX_THRESH_EN.
module zynet_argmax_classifier #(
   parameter int OUTPUT_SIZE = 10,
   parameter int WORD_SIZE   = 16,
   parameter int INT_BITS    = 4,
   localparam int IDX_W      = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1
) (
   input  logic                                  clk_i,
   input  logic                                  reset_i,
   input  logic                                  valid_i,
   output logic                                  yumi_o,
   input  logic [OUTPUT_SIZE-1:0][WORD_SIZE-1:0] data_i,
   output logic                                  valid_o,
   input  logic                                  ready_i,
`ifdef ZYNET_ARGMAX_THRESH_EN
   input  logic [WORD_SIZE-1:0]                  thresh_i,
   output logic                                  reject_o,
`endif
   output logic [IDX_W-1:0]                      class_o,
   output logic [WORD_SIZE-1:0]                  score_o,
   output logic                                  busy_o
);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUTPUT_SIZE - 1);
   localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

   if (OUTPUT_SIZE < 1 || INT_BITS < 1 || INT_BITS > WORD_SIZE) begin : g_param_check
      $error("zynet_argmax_classifier: illegal OUTPUT_SIZE/INT_BITS/WORD_SIZE");
   end

   state_t                 state_reg, state_next;
   logic [WORD_SIZE-1:0]   vec_reg [OUTPUT_SIZE];
   logic [WORD_SIZE-1:0]   best_reg, best_next;
   logic [IDX_W-1:0]       best_idx_reg, best_idx_next;
   logic [IDX_W-1:0]       k_reg, k_next;
   logic                   accept;

   assign accept = (state_reg == IDLE) && valid_i;

   // FSM state register
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state_reg <= IDLE;
      else         state_reg <= state_next;
   end

   // FSM next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (valid_i) state_next = (OUTPUT_SIZE == 1) ? DONE : SCAN;
         SCAN:    if (k_reg == LAST_IDX) state_next = DONE;
         DONE:    if (ready_i) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      yumi_o  = 1'b0;
      valid_o = 1'b0;
      busy_o  = 1'b0;
      case (state_reg)
         IDLE:    yumi_o = valid_i;
         SCAN:    busy_o = 1'b1;
         DONE: begin
            busy_o  = 1'b1;
            valid_o = 1'b1;
         end
         default: ;
      endcase
   end

   // Vector is captured whole on acceptance so upstream may change data_i during the scan
   for (genvar gi = 0; gi < OUTPUT_SIZE; gi++) begin : g_vec
      always_ff @(posedge clk_i or posedge reset_i) begin
         if (reset_i)     vec_reg[gi] <= '0;
         else if (accept) vec_reg[gi] <= data_i[gi];
      end
   end

   // Strict signed greater-than: ties keep the lower index
   always_comb begin
      best_next     = best_reg;
      best_idx_next = best_idx_reg;
      k_next        = k_reg;
      if (accept) begin
         best_next     = data_i[0];
         best_idx_next = '0;
         k_next        = ONE_IDX;
      end else if (state_reg == SCAN) begin
         if ($signed(vec_reg[k_reg]) > $signed(best_reg)) begin
            best_next     = vec_reg[k_reg];
            best_idx_next = k_reg;
         end
         k_next = k_reg + ONE_IDX;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         best_reg     <= '0;
         best_idx_reg <= '0;
         k_reg        <= '0;
      end else begin
         best_reg     <= best_next;
         best_idx_reg <= best_idx_next;
         k_reg        <= k_next;
      end
   end

   assign class_o = best_idx_reg;
   assign score_o = best_reg;

`ifdef ZYNET_ARGMAX_THRESH_EN
   logic reject_reg;

   // Sampled once, on entry to DONE, from the final best value
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)
         reject_reg <= 1'b0;
      else if (state_next == DONE && state_reg != DONE)
         reject_reg <= $signed(best_next) < $signed(thresh_i);
   end

   assign reject_o = reject_reg;
`endif

endmodule

// File: tb/tb_zynet_argmax_classifier.sv
// Self-checking bench for zynet_argmax_classifier: directed table, handshake corner cases, random vectors.
module tb_zynet_argmax_classifier;
   localparam int N  = 10;
   localparam int W  = 16;
   localparam int IW = 4;

   typedef logic [N-1:0][W-1:0] vec_t;
   typedef struct {
      string        name;
      vec_t         d;
      int           exp_cls;
      logic [W-1:0] exp_score;
   } rec_t;

   logic         clk_i = 1'b0;
   logic         reset_i, valid_i, yumi_o, valid_o, ready_i, busy_o;
   vec_t         data_i;
   logic [IW-1:0] class_o;
   logic [W-1:0] score_o;
`ifdef ZYNET_ARGMAX_THRESH_EN
   logic [W-1:0] thresh_i = 16'h0800;
   logic         reject_o;
`endif

   int n_cmp = 0;
   int n_err = 0;
   rec_t tbl [7];

   always #5 clk_i = ~clk_i;

   zynet_argmax_classifier #(.OUTPUT_SIZE(N), .WORD_SIZE(W), .INT_BITS(4)) dut (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .valid_i (valid_i),
      .yumi_o  (yumi_o),
      .data_i  (data_i),
      .valid_o (valid_o),
      .ready_i (ready_i),
`ifdef ZYNET_ARGMAX_THRESH_EN
      .thresh_i(thresh_i),
      .reject_o(reject_o),
`endif
      .class_o (class_o),
      .score_o (score_o),
      .busy_o  (busy_o)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: largest signed value, then the lowest index holding it
   function automatic void ref_argmax(input vec_t d, output int cls, output logic [W-1:0] scr);
      int mx;
      mx = int'($signed(d[0]));
      for (int i = 1; i < N; i++)
         if (int'($signed(d[i])) > mx) mx = int'($signed(d[i]));
      cls = 0;
      for (int i = N - 1; i >= 0; i--)
         if (int'($signed(d[i])) == mx) cls = i;
      scr = W'(mx);
   endfunction

   // Waits (bounded) for valid_o, starting at the negedge after the acceptance edge
   task automatic wait_valid(input string name);
      int lat;
      lat = 0;
      while (!valid_o && lat < 100) begin
         @(posedge clk_i);
         lat++;
         @(negedge clk_i);
      end
      check({name, " latency"}, 32'(lat), 32'(N - 1));
   endtask

   // One full transaction with ready_i held high from before acceptance
   task automatic run_vec(input string name, input vec_t d, input int exp_cls, input logic [W-1:0] exp_score);
      @(negedge clk_i);
      data_i  = d;
      valid_i = 1'b1;
      ready_i = 1'b1;
      #1 check({name, " yumi"}, 32'(yumi_o), 32'(1));
      @(posedge clk_i);
      @(negedge clk_i);
      valid_i = 1'b0;
      data_i  = ~d;
      check({name, " busy"}, 32'(busy_o), 32'(1));
      wait_valid(name);
      check({name, " class"}, 32'(class_o), 32'(exp_cls));
      check({name, " score"}, 32'(score_o), 32'(exp_score));
      $display("vec %s: class %0d score 0x%04h", name, class_o, score_o);
      @(posedge clk_i);
      @(negedge clk_i);
      check({name, " valid drop"}, 32'(valid_o), 32'(0));
      ready_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t a, b;
      int   cls;
      logic [W-1:0] scr;

      // Directed table
      tbl[0].name = "basic";    tbl[0].d = '0;
      tbl[0].d[0] = 16'h0100; tbl[0].d[1] = 16'h0200; tbl[0].d[2] = 16'h7000; tbl[0].d[3] = 16'h0010;
      tbl[0].exp_cls = 2; tbl[0].exp_score = 16'h7000;
      tbl[1].name = "negative";
      for (int i = 0; i < N; i++) tbl[1].d[i] = 16'h8000 + 16'(i * 10);
      tbl[1].d[7] = 16'hFFF0;
      tbl[1].exp_cls = 7; tbl[1].exp_score = 16'hFFF0;
      tbl[2].name = "tie";      tbl[2].d = '0;
      tbl[2].d[3] = 16'h1234; tbl[2].d[8] = 16'h1234;
      tbl[2].exp_cls = 3; tbl[2].exp_score = 16'h1234;
      tbl[3].name = "all_zero"; tbl[3].d = '0;
      tbl[3].exp_cls = 0; tbl[3].exp_score = 16'h0000;
      tbl[4].name = "max_last";
      for (int i = 0; i < N; i++) tbl[4].d[i] = 16'h0001;
      tbl[4].d[0] = 16'h8000; tbl[4].d[9] = 16'h7FFF;
      tbl[4].exp_cls = 9; tbl[4].exp_score = 16'h7FFF;
      tbl[5].name = "all_min";
      for (int i = 0; i < N; i++) tbl[5].d[i] = 16'h8000;
      tbl[5].exp_cls = 0; tbl[5].exp_score = 16'h8000;
      tbl[6].name = "max_first";
      for (int i = 0; i < N; i++) tbl[6].d[i] = 16'hFFFF;
      tbl[6].d[0] = 16'h0001;
      tbl[6].exp_cls = 0; tbl[6].exp_score = 16'h0001;

      // Reset state
      reset_i = 1'b1;
      valid_i = 1'b0;
      ready_i = 1'b0;
      data_i  = '0;
      #1;
      check("reset valid_o", 32'(valid_o), 32'(0));
      check("reset yumi_o",  32'(yumi_o),  32'(0));
      check("reset busy_o",  32'(busy_o),  32'(0));
      check("reset class_o", 32'(class_o), 32'(0));
      check("reset score_o", 32'(score_o), 32'(0));
`ifdef ZYNET_ARGMAX_THRESH_EN
      check("reset reject_o", 32'(reject_o), 32'(0));
`endif
      repeat (2) @(negedge clk_i);
      reset_i = 1'b0;

      for (int t = 0; t < 7; t++)
         run_vec(tbl[t].name, tbl[t].d, tbl[t].exp_cls, tbl[t].exp_score);

      // Backpressure: DONE held 20 cycles while a new vector waits on valid_i
      a = tbl[0].d;
      b = tbl[2].d;
      @(negedge clk_i);
      data_i = a; valid_i = 1'b1; ready_i = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      data_i = b;
      check("bp scan yumi", 32'(yumi_o), 32'(0));
      wait_valid("bp A");
      for (int c = 0; c < 20; c++) begin
         check("bp hold valid", 32'(valid_o), 32'(1));
         check("bp hold yumi",  32'(yumi_o),  32'(0));
         check("bp hold class", 32'(class_o), 32'(2));
         check("bp hold score", 32'(score_o), 32'(16'h7000));
         @(posedge clk_i);
         @(negedge clk_i);
      end
      ready_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      check("bp handshake valid", 32'(valid_o), 32'(0));
      check("bp idle yumi",       32'(yumi_o),  32'(1));
      @(posedge clk_i);
      @(negedge clk_i);
      valid_i = 1'b0;
      check("bp B busy", 32'(busy_o), 32'(1));
      wait_valid("bp B");
      check("bp B class", 32'(class_o), 32'(3));
      check("bp B score", 32'(score_o), 32'(16'h1234));
      $display("vec backpressure: class %0d score 0x%04h", class_o, score_o);
      @(posedge clk_i);
      @(negedge clk_i);
      ready_i = 1'b0;

      // Reset mid-scan, 4 cycles after acceptance
      @(negedge clk_i);
      data_i = tbl[0].d; valid_i = 1'b1;
      @(posedge clk_i);
      repeat (4) @(posedge clk_i);
      #2 reset_i = 1'b1;
      valid_i = 1'b0;
      #1;
      check("rst scan valid_o", 32'(valid_o), 32'(0));
      check("rst scan busy_o",  32'(busy_o),  32'(0));
      check("rst scan score_o", 32'(score_o), 32'(0));
      @(negedge clk_i);
      reset_i = 1'b0;
      $display("vec reset_mid_scan: valid %0d busy %0d", valid_o, busy_o);
      run_vec("after_rst", tbl[1].d, 7, 16'hFFF0);

      // Reset while holding in DONE
      @(negedge clk_i);
      data_i = tbl[4].d; valid_i = 1'b1; ready_i = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      valid_i = 1'b0;
      wait_valid("rst done");
      #2 reset_i = 1'b1;
      #1;
      check("rst done valid_o", 32'(valid_o), 32'(0));
      check("rst done busy_o",  32'(busy_o),  32'(0));
      check("rst done class_o", 32'(class_o), 32'(0));
      @(negedge clk_i);
      reset_i = 1'b0;
      $display("vec reset_in_done: valid %0d busy %0d", valid_o, busy_o);

`ifdef ZYNET_ARGMAX_THRESH_EN
      a = '0; a[5] = 16'h0400; a[1] = 16'hF000;
      run_vec("thresh_low", a, 5, 16'h0400);
      check("thresh_low reject", 32'(reject_o), 32'(1));
      a = '0; a[6] = 16'h0800;
      run_vec("thresh_eq", a, 6, 16'h0800);
      check("thresh_eq reject", 32'(reject_o), 32'(0));
`endif

      // Random vectors against the reference model
      for (int r = 0; r < 40; r++) begin
         for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 2))
               0: a[i] = 16'($urandom);
               1: case ($urandom_range(0, 3))
                     0: a[i] = 16'h0000;
                     1: a[i] = 16'h7FFF;
                     2: a[i] = 16'h8000;
                     default: a[i] = 16'hFFFF;
                  endcase
               default: a[i] = 16'($urandom_range(0, 3));
            endcase
         end
         ref_argmax(a, cls, scr);
         run_vec($sformatf("rand%0d", r), a, cls, scr);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
